dose_counter_multi: RTL and testbench

- Parametrised N-channel successor to the single-channel grain-pulse counter of the dispenser.
- Each channel synchronises and glitch-filters its grain sensor, and counts accepted rising edges against a per-channel target latched at start.
- Each channel drives a valve enable while dosing and reports completion or abort with one-cycle pulses.
- Sits between the dispenser control FSM (start/abort/target) and the valve drivers.

---
 rtl/dose_counter_multi.sv | 204 ++++++++++++++++++++
 tb/tb_dose_counter_multi.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dose_counter_multi.sv
// -----------------------------------------------------------------------------
// dose_counter_multi
//
// N-channel grain dosing counter. Every channel owns a grain sensor, a valve
// enable and a small IDLE/RUN/DONE controller. The sensor is synchronised,
// glitch-filtered, and each accepted rising edge of the filtered level adds one
// to the channel count while the channel is dosing. The dose ends when the
// count reaches the target latched at start, or when the channel is aborted.
//
// Command semantics: start and abort are level inputs sampled on every rising
// clock edge; there is no ready/acknowledge. A start is taken only in IDLE
// (abort wins over start on the same edge) and is ignored in RUN and DONE. An
// abort is acted on only in RUN. The outcome of a dose is reported by a
// one-cycle done or aborted pulse; valve_on and busy are plain status levels.
//
// Parameters:
//   CHANNELS       number of independent dosing channels (1..16)
//   WIDTH          width of the per-channel target and count
//   SYNC_STAGES    synchroniser depth on each sensor input (>=2)
//   FILTER_CYCLES  consecutive disagreeing cycles before the filtered level
//                  flips (>=1)
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   reset      in   asynchronous active-low reset
//   start      in   [CHANNELS]        per-channel dose request
//   abort      in   [CHANNELS]        per-channel abort
//   sensor_in  in   [CHANNELS]        raw asynchronous grain sensor pulses
//   target     in   [CHANNELS*WIDTH]  per-channel target, channel i at
//                                     [i*WIDTH +: WIDTH]
//   valve_on   out  [CHANNELS]        valve enable, high only in RUN
//   count      out  [CHANNELS*WIDTH]  accepted pulses of current/last dose
//   done       out  [CHANNELS]        one-cycle pulse when a dose completes
//   aborted    out  [CHANNELS]        one-cycle pulse when a dose is aborted
//   busy       out  1                 OR of all channels in RUN
//
// Debug: the per-channel controller state is visible on the internal array
// chan_state, which also drives busy.
// -----------------------------------------------------------------------------
module dose_counter_multi #(
   parameter int CHANNELS      = 4,
   parameter int WIDTH         = 8,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       start,
   input  logic [CHANNELS-1:0]       abort,
   input  logic [CHANNELS-1:0]       sensor_in,
   input  logic [CHANNELS*WIDTH-1:0] target,
   output logic [CHANNELS-1:0]       valve_on,
   output logic [CHANNELS*WIDTH-1:0] count,
   output logic [CHANNELS-1:0]       done,
   output logic [CHANNELS-1:0]       aborted,
   output logic                      busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // The filter counter only has to hold 0..FILTER_CYCLES-1: the cycle that
   // would make it reach FILTER_CYCLES flips the level and clears it instead.
   localparam int             FCW       = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_CYCLES - 1);

   // Per-channel controller state, exported for observation and used for busy.
   state_t chan_state [CHANNELS];

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan

      // ---------------------------------------------------------------
      // Sensor front end: synchroniser, persistence filter, edge detect
      // ---------------------------------------------------------------
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   synced;
      logic                   filt_q;
      logic                   filt_prev_q;
      logic [FCW-1:0]         filt_cnt_q;
      logic                   accept;

      assign synced = sync_q[SYNC_STAGES-1];
      // One-cycle strobe on a 0->1 move of the filtered level.
      assign accept = filt_q & ~filt_prev_q;

      always_ff @(posedge clk or negedge reset) begin : p_filter
         if (!reset) begin
            sync_q      <= '0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            filt_cnt_q  <= '0;
         end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], sensor_in[gi]};
            filt_prev_q <= filt_q;
            // The filter runs in every controller state, so a sensor that is
            // already high when a dose starts is already reflected in filt_q
            // and cannot produce an edge.
            if (synced != filt_q) begin
               if (filt_cnt_q == FILT_LAST) begin
                  filt_q     <= ~filt_q;
                  filt_cnt_q <= '0;
               end else begin
                  filt_cnt_q <= filt_cnt_q + FCW'(1);
               end
            end else begin
               filt_cnt_q <= '0;
            end
         end
      end

      // ---------------------------------------------------------------
      // Dose controller
      // ---------------------------------------------------------------
      state_t           state_q;
      logic [WIDTH-1:0] tgt_in;
      logic [WIDTH-1:0] tgt_q;
      logic [WIDTH-1:0] count_q;
      logic [WIDTH-1:0] count_next;
      logic             valve_q;
      logic             done_q;
      logic             aborted_q;

      assign tgt_in     = target[gi*WIDTH +: WIDTH];
      assign count_next = count_q + WIDTH'(1);

      always_ff @(posedge clk or negedge reset) begin : p_fsm
         if (!reset) begin
            state_q   <= ST_IDLE;
            tgt_q     <= '0;
            count_q   <= '0;
            valve_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
         end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
               ST_IDLE: begin
                  if (!abort[gi] && start[gi]) begin
                     tgt_q   <= tgt_in;
                     count_q <= '0;
                     if (tgt_in != '0) begin
                        state_q <= ST_RUN;
                        valve_q <= 1'b1;
                     end else begin
                        // Nothing to dispense: report completion without
                        // ever opening the valve.
                        state_q <= ST_DONE;
                     end
                  end
               end

               ST_RUN: begin
                  if (abort[gi]) begin
                     // Abort takes priority over a pulse on the same edge,
                     // so the count keeps its pre-abort value.
                     state_q   <= ST_IDLE;
                     valve_q   <= 1'b0;
                     aborted_q <= 1'b1;
                  end else if (accept) begin
                     count_q <= count_next;
                     // Close the valve on the very edge that writes the
                     // final count. The count stops at the target, so it
                     // never wraps even for an all-ones target.
                     if (count_next == tgt_q) begin
                        state_q <= ST_DONE;
                        valve_q <= 1'b0;
                     end
                  end
               end

               ST_DONE: begin
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end

               default: begin
                  state_q <= ST_IDLE;
                  valve_q <= 1'b0;
               end
            endcase
         end
      end

      assign chan_state[gi]              = state_q;
      assign valve_on[gi]                = valve_q;
      assign done[gi]                    = done_q;
      assign aborted[gi]                 = aborted_q;
      assign count[gi*WIDTH +: WIDTH]    = count_q;
   end

   always_comb begin
      busy = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (chan_state[c] == ST_RUN) begin
            busy = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dose_counter_multi.sv
// -----------------------------------------------------------------------------
// tb_dose_counter_multi
//
// Bench for dose_counter_multi with CHANNELS=4, WIDTH=8, SYNC_STAGES=2,
// FILTER_CYCLES=4. Inputs change 1 time unit after a rising edge and outputs
// are read at that point, i.e. they show the result of the edge just taken.
// Completion and abort events are predicted into exp_q as {channel, kind,
// count} (kind 1 = done, 0 = aborted) and consumed by the event monitor.
// -----------------------------------------------------------------------------
module tb_dose_counter_multi;

   localparam int CH = 4;
   localparam int W  = 8;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   logic [CH-1:0]   start     = '0;
   logic [CH-1:0]   abort     = '0;
   logic [CH-1:0]   sensor_in = '0;
   logic [CH*W-1:0] target    = '0;
   logic [CH-1:0]   valve_on;
   logic [CH*W-1:0] count;
   logic [CH-1:0]   done;
   logic [CH-1:0]   aborted;
   logic            busy;

   int checks   = 0;
   int failures = 0;

   logic [12:0] exp_q[$];
   logic [12:0] mon_got;
   logic [12:0] mon_exp;

   dose_counter_multi #(
      .CHANNELS      (CH),
      .WIDTH         (W),
      .SYNC_STAGES   (2),
      .FILTER_CYCLES (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .sensor_in (sensor_in),
      .target    (target),
      .valve_on  (valve_on),
      .count     (count),
      .done      (done),
      .aborted   (aborted),
      .busy      (busy)
   );

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   // ---------------- scoreboard: event monitor ----------------
   always @(negedge clk) begin
      for (int c = 0; c < CH; c++) begin
         if (done[c] || aborted[c]) begin
            mon_got = {4'(c), done[c], count[c*W +: W]};
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL event_unexpected ch=%0d got=%h required=none", c, mon_got);
            end else begin
               mon_exp = exp_q.pop_front();
               if (mon_got !== mon_exp) begin
                  failures++;
                  $display("FAIL event_ch%0d got=%h required=%h", c, mon_got, mon_exp);
               end
            end
         end
      end
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      #2 reset = 1'b0;
      steps(3);
      checks++;
      if (valve_on !== 4'b0) begin failures++; $display("FAIL reset_valve_on got=%b required=0000", valve_on); end
      checks++;
      if (count !== 32'h0) begin failures++; $display("FAIL reset_count got=%h required=00000000", count); end
      checks++;
      if (done !== 4'b0 || aborted !== 4'b0) begin
         failures++; $display("FAIL reset_pulses done=%b aborted=%b required=0000", done, aborted);
      end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy); end
      reset = 1'b1;
      steps(2);
      checks++;
      if (valve_on !== 4'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL reset_release valve_on=%b busy=%b required=0000/0", valve_on, busy);
      end
   endtask

   task automatic test_single_channel();
      target[0 +: W] = 8'd5;
      start[0] = 1'b1;
      step();
      start[0] = 1'b0;
      checks++;
      if (valve_on !== 4'b0001 || busy !== 1'b1 || count[0 +: W] !== 8'd0) begin
         failures++;
         $display("FAIL single_start valve_on=%b busy=%b count=%0d required=0001/1/0", valve_on, busy, count[0 +: W]);
      end
      exp_q.push_back({4'd0, 1'b1, 8'd5});
      for (int k = 1; k <= 5; k++) begin
         sensor_in[0] = 1'b1;
         for (int j = 1; j <= 10; j++) begin
            step();
            if (j == 6) begin
               checks++;
               if (count[0 +: W] !== 8'(k - 1)) begin
                  failures++; $display("FAIL single_latency_pre k=%0d got=%0d required=%0d", k, count[0 +: W], k - 1);
               end
            end
            if (j == 7) begin
               checks++;
               if (count[0 +: W] !== 8'(k)) begin
                  failures++; $display("FAIL single_count k=%0d got=%0d required=%0d", k, count[0 +: W], k);
               end
               checks++;
               if (valve_on[0] !== ((k < 5) ? 1'b1 : 1'b0) || done[0] !== 1'b0) begin
                  failures++; $display("FAIL single_valve k=%0d valve=%b done=%b required=%b/0", k, valve_on[0], done[0], (k < 5));
               end
            end
            if (j == 8 && k == 5) begin
               checks++;
               if (done[0] !== 1'b1 || valve_on[0] !== 1'b0) begin
                  failures++; $display("FAIL single_done done=%b valve=%b required=1/0", done[0], valve_on[0]);
               end
            end
            if (j == 9 && k == 5) begin
               checks++;
               if (done[0] !== 1'b0) begin
                  failures++; $display("FAIL single_done_width got=%b required=0", done[0]);
               end
            end
         end
         sensor_in[0] = 1'b0;
         steps(10);
      end
      checks++;
      if (count[W +: 3*W] !== 24'h0 || valve_on !== 4'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL single_others count=%h valve_on=%b busy=%b required=000000/0000/0", count[W +: 3*W], valve_on, busy);
      end
   endtask

   task automatic test_glitch();
      target[W +: W] = 8'd3;
      start[1] = 1'b1;
      step();
      start[1] = 1'b0;
      checks++;
      if (valve_on[1] !== 1'b1) begin failures++; $display("FAIL glitch_start valve=%b required=1", valve_on[1]); end
      for (int g = 1; g <= 3; g++) begin
         sensor_in[1] = 1'b1;
         steps(g);
         sensor_in[1] = 1'b0;
         steps(8);
      end
      checks++;
      if (count[W +: W] !== 8'd0) begin
         failures++; $display("FAIL glitch_rejected got=%0d required=0", count[W +: W]);
      end
      exp_q.push_back({4'd1, 1'b1, 8'd3});
      for (int k = 1; k <= 3; k++) begin
         sensor_in[1] = 1'b1;
         steps(10);
         sensor_in[1] = 1'b0;
         steps(10);
         checks++;
         if (count[W +: W] !== 8'(k)) begin
            failures++; $display("FAIL glitch_count k=%0d got=%0d required=%0d", k, count[W +: W], k);
         end
      end
      checks++;
      if (valve_on[1] !== 1'b0 || exp_q.size() != 0) begin
         failures++; $display("FAIL glitch_done valve=%b pending=%0d required=0/0", valve_on[1], exp_q.size());
      end
   endtask

   task automatic test_abort();
      target[3*W +: W] = 8'd10;
      start[3] = 1'b1;
      step();
      start[3] = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         sensor_in[3] = 1'b1;
         steps(10);
         sensor_in[3] = 1'b0;
         steps(10);
      end
      checks++;
      if (count[3*W +: W] !== 8'd4) begin
         failures++; $display("FAIL abort_pre_count got=%0d required=4", count[3*W +: W]);
      end
      exp_q.push_back({4'd3, 1'b0, 8'd4});
      sensor_in[3] = 1'b1;
      steps(6);
      abort[3] = 1'b1;
      step();
      abort[3] = 1'b0;
      checks++;
      if (aborted[3] !== 1'b1 || done[3] !== 1'b0) begin
         failures++; $display("FAIL abort_pulse aborted=%b done=%b required=1/0", aborted[3], done[3]);
      end
      checks++;
      if (count[3*W +: W] !== 8'd4 || valve_on[3] !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_state count=%0d valve=%b busy=%b required=4/0/0", count[3*W +: W], valve_on[3], busy);
      end
      step();
      checks++;
      if (aborted[3] !== 1'b0) begin failures++; $display("FAIL abort_width got=%b required=0", aborted[3]); end
      steps(2);
      sensor_in[3] = 1'b0;
      steps(10);
      sensor_in[3] = 1'b1;
      steps(10);
      sensor_in[3] = 1'b0;
      steps(10);
      checks++;
      if (count[3*W +: W] !== 8'd4) begin
         failures++; $display("FAIL abort_idle_hold got=%0d required=4", count[3*W +: W]);
      end
   endtask

   task automatic test_all_channels();
      logic [CH-1:0] vm;
      target = {8'd8, 8'd6, 8'd4, 8'd2};
      start = 4'hF;
      step();
      start = 4'h0;
      checks++;
      if (valve_on !== 4'hF || busy !== 1'b1 || count !== 32'h0) begin
         failures++; $display("FAIL all_start valve_on=%b busy=%b count=%h required=1111/1/0", valve_on, busy, count);
      end
      for (int c = 0; c < CH; c++) exp_q.push_back({4'(c), 1'b1, 8'(2 * (c + 1))});
      for (int k = 1; k <= 8; k++) begin
         sensor_in = 4'hF;
         steps(10);
         sensor_in = 4'h0;
         steps(10);
         for (int c = 0; c < CH; c++) begin
            vm[c] = (k < 2 * (c + 1));
            checks++;
            if (count[c*W +: W] !== 8'((k < 2 * (c + 1)) ? k : 2 * (c + 1))) begin
               failures++;
               $display("FAIL all_count k=%0d ch=%0d got=%0d required=%0d", k, c, count[c*W +: W],
                        (k < 2 * (c + 1)) ? k : 2 * (c + 1));
            end
         end
         checks++;
         if (valve_on !== vm || busy !== (k < 8)) begin
            failures++; $display("FAIL all_valve k=%0d valve_on=%b busy=%b required=%b/%0d", k, valve_on, busy, vm, (k < 8));
         end
      end
   endtask

   task automatic test_zero_target();
      target[2*W +: W] = 8'd0;
      exp_q.push_back({4'd2, 1'b1, 8'd0});
      start[2] = 1'b1;
      step();
      checks++;
      if (count[2*W +: W] !== 8'd0 || done[2] !== 1'b0 || valve_on[2] !== 1'b0) begin
         failures++;
         $display("FAIL zero_first count=%0d done=%b valve=%b required=0/0/0", count[2*W +: W], done[2], valve_on[2]);
      end
      // start still high while in DONE: must be ignored
      step();
      start[2] = 1'b0;
      checks++;
      if (done[2] !== 1'b1 || valve_on[2] !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL zero_done done=%b valve=%b busy=%b required=1/0/0", done[2], valve_on[2], busy);
      end
      step();
      checks++;
      if (done[2] !== 1'b0 || valve_on[2] !== 1'b0) begin
         failures++; $display("FAIL zero_after done=%b valve=%b required=0/0", done[2], valve_on[2]);
      end
      steps(3);
   endtask

   task automatic test_reset_mid_run();
      target[0 +: W] = 8'd5;
      start[0] = 1'b1;
      step();
      start[0] = 1'b0;
      sensor_in[0] = 1'b1;
      steps(10);
      sensor_in[0] = 1'b0;
      steps(10);
      checks++;
      if (count[0 +: W] !== 8'd1 || valve_on[0] !== 1'b1) begin
         failures++; $display("FAIL midrst_pre count=%0d valve=%b required=1/1", count[0 +: W], valve_on[0]);
      end
      sensor_in[0] = 1'b1;
      #2 reset = 1'b0;
      #1;
      checks++;
      if (valve_on !== 4'b0 || count !== 32'h0 || busy !== 1'b0) begin
         failures++; $display("FAIL midrst_async valve_on=%b count=%h busy=%b required=0000/0/0", valve_on, count, busy);
      end
      checks++;
      if (done !== 4'b0 || aborted !== 4'b0) begin
         failures++; $display("FAIL midrst_pulses done=%b aborted=%b required=0000", done, aborted);
      end
      steps(3);
      reset = 1'b1;
      steps(20);
      target[0 +: W] = 8'd3;
      start[0] = 1'b1;
      step();
      start[0] = 1'b0;
      checks++;
      if (valve_on[0] !== 1'b1) begin failures++; $display("FAIL midrst_restart valve=%b required=1", valve_on[0]); end
      steps(15);
      checks++;
      if (count[0 +: W] !== 8'd0) begin
         failures++; $display("FAIL midrst_held_high got=%0d required=0", count[0 +: W]);
      end
      sensor_in[0] = 1'b0;
      steps(10);
      sensor_in[0] = 1'b1;
      steps(10);
      checks++;
      if (count[0 +: W] !== 8'd1) begin
         failures++; $display("FAIL midrst_new_edge got=%0d required=1", count[0 +: W]);
      end
      exp_q.push_back({4'd0, 1'b0, 8'd1});
      abort[0] = 1'b1;
      step();
      abort[0] = 1'b0;
      checks++;
      if (aborted[0] !== 1'b1 || valve_on[0] !== 1'b0) begin
         failures++; $display("FAIL midrst_abort aborted=%b valve=%b required=1/0", aborted[0], valve_on[0]);
      end
      sensor_in[0] = 1'b0;
      steps(10);
   endtask

   // ---------------- main sequence + report ----------------
   initial begin
      test_reset();
      test_single_channel();
      test_glitch();
      test_abort();
      test_all_channels();
      test_zero_target();
      test_reset_mid_run();
      steps(2);
      checks++;
      if (exp_q.size() != 0) begin
         failures++; $display("FAIL events_pending got=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog time=%0t required=finish", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
